// File: rtl/secure_memory_store.sv
`default_nettype none
// ============================================================================
// Module      : secure_memory_store
// Description : Avalon-MM slave word store with fixed one-cycle read latency.
//               Out-of-window or misaligned accesses are counted; reaching the
//               violation threshold zeroises the whole array, then locks the
//               store until an explicit unlock pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module secure_memory_store #(
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_VIOLATIONS = 3,
    parameter int          VCOUNT_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             address,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic [3:0]              byteenable,
    output logic [31:0]             readdata,
    output logic                    waitrequest,
    input  logic                    unlock,
    output logic                    locked,
    output logic                    scrub_busy,
    output logic [VCOUNT_WIDTH-1:0] violation_count
);

    localparam int                     DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [VCOUNT_WIDTH-1:0] VCOUNT_MAX = '1;
    localparam logic [VCOUNT_WIDTH-1:0] VIOL_LIMIT = VCOUNT_WIDTH'(MAX_VIOLATIONS);
    // One extra bit so the scrub pointer can reach DEPTH without wrapping
    localparam logic [ADDR_WIDTH:0]     SCRUB_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_SCRUB  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [31:0]             mem [DEPTH];
    logic [ADDR_WIDTH:0]     scrub_idx;

    logic [ADDR_WIDTH-1:0]   idx;
    logic                    in_window;
    logic                    is_violation;
    logic                    trip;
    logic                    mem_wr;
    logic                    mem_rd;
    logic [VCOUNT_WIDTH-1:0] count_inc;

    assign idx       = address[ADDR_WIDTH+1:2];
    assign in_window = (address[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]) &&
                       (address[1:0] == 2'b00);

    // A write with no byte lanes enabled is a harmless no-op, never a violation
    assign is_violation = (state == ST_NORMAL) && chipselect && !in_window &&
                          !(write && (byteenable == 4'b0000));
    assign count_inc    = (violation_count == VCOUNT_MAX) ? violation_count
                                                          : violation_count + 1'b1;
    assign trip         = is_violation && (count_inc == VIOL_LIMIT);
    assign mem_wr       = (state == ST_NORMAL) && chipselect && write && in_window;
    assign mem_rd       = (state == ST_NORMAL) && chipselect && !write && in_window;

    // Next-state and state-decoded outputs
    always_comb begin
        state_next  = state;
        waitrequest = 1'b0;
        locked      = 1'b0;
        scrub_busy  = 1'b0;
        case (state)
            ST_NORMAL: begin
                if (trip) begin
                    state_next = ST_SCRUB;
                end
            end
            ST_SCRUB: begin
                waitrequest = 1'b1;
                scrub_busy  = 1'b1;
                if (scrub_idx == SCRUB_LAST) begin
                    state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                locked = 1'b1;
                if (unlock) begin
                    state_next = ST_NORMAL;
                end
            end
            default: state_next = ST_NORMAL;
        endcase
    end

    // State register, violation counter, scrub pointer and registered read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_NORMAL;
            violation_count <= '0;
            scrub_idx       <= '0;
            readdata        <= 32'h0;
        end else begin
            state <= state_next;

            if (is_violation) begin
                violation_count <= count_inc;
            end else if ((state == ST_LOCKED) && unlock) begin
                violation_count <= '0;
            end

            if (state == ST_SCRUB) begin
                scrub_idx <= scrub_idx + 1'b1;
            end else begin
                scrub_idx <= '0;
            end

            // Scrubbing forces zero; otherwise only reads update the output
            if (state == ST_SCRUB) begin
                readdata <= 32'h0;
            end else if (chipselect && !write) begin
                readdata <= mem_rd ? mem[idx] : 32'h0;
            end
        end
    end

    // Storage array: not reset, so a reset mid-scrub leaves unscrubbed words intact
    always_ff @(posedge clk) begin
        if (state == ST_SCRUB) begin
            mem[scrub_idx[ADDR_WIDTH-1:0]] <= 32'h0;
        end else if (mem_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (byteenable[k]) begin
                    mem[idx][8*k +: 8] <= writedata[8*k +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
